iter_div: RTL and testbench
===========================

# iter_div

Iterative radix-2 restoring divider for the DIV/DIVU instructions of the 54-instruction MIPS core. Accepts one signed or unsigned 32-bit division per request, computes quotient and remainder over a fixed number of cycles, and drives the `busy` signal that the next-PC selector uses to hold the PC while a division is in flight. Results feed the HI/LO write path (LO = quotient, HI = remainder).

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  division request; sampled only in IDLE.
- `cancel`  in  1  flush, e.g. on exception; aborts an operation in RUN.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend`  in  32  numerator; sampled with `start`.
- `divisor`  in  32  denominator; sampled with `start`.
- `q`  out  32  quotient, registered.
- `r`  out  32  remainder, registered.
- `busy`  out  1  stall request to the next-PC selector.
- `done`  out  1  one-cycle result-valid pulse.

## Operation
- FSM states: IDLE, RUN, DONE. Iteration counter is 5 bits; partial remainder is 33 bits.
- **IDLE**
  - `start=1` and `cancel=0`: latch operand magnitudes, signs and `is_signed`; clear the counter; go to RUN.
  - `cancel` takes priority over `start` in IDLE.
- **RUN**
  - One restoring step per cycle: shift the remainder left with the next dividend bit, trial-subtract the divisor magnitude, keep the result if it is non-negative, and shift the quotient bit in.
  - After 32 steps, go to DONE.
  - `cancel=1` in RUN: go to IDLE, no `done` pulse, `q`/`r` unchanged.
- **DONE**
  - Drive `done=1` for exactly one cycle, then go to IDLE.
  - `start` is ignored, because the issuing instruction is still present this cycle.
  - `cancel` has no effect.
- **Signed handling**
  - Divide the magnitudes.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- **Overflow:** signed 0x80000000 / 0xFFFFFFFF gives `q`=0x80000000, `r`=0.
- **Divide by zero** (either mode): `q`=0xFFFFFFFF, `r`=`dividend` (raw operand). No exception.
- `q`/`r` are written only at the RUN→DONE edge. They hold until the next completed operation.
- `busy` is combinational: `busy = (IDLE & start & ~cancel) | RUN`. It is 0 in DONE, so the PC advances at the end of the DONE cycle.

## Timing
- Cycle 0: `start` sampled in IDLE, `busy=1` in the same cycle.
- Cycles 1–32: RUN, `busy=1`.
- Cycle 33: DONE, `done=1`, `busy=0`, `q`/`r` valid.
- Cycle 34: IDLE; a new `start` is accepted.
- Total stall: 33 cycles per division.
- Back-to-back divisions: the earliest next accepted `start` is cycle 34.
- Reset values: state IDLE, `q`=0, `r`=0, `done`=0, `busy`=0 while `rst_n`=0 regardless of `start`, counter=0.
- `rst_n` asserted mid-RUN: immediate return to IDLE, all outputs to reset values, no `done`.
- `cancel` in RUN cycle k: state is IDLE in cycle k+1; `busy` is 0 from cycle k+1, unless `start` is then asserted.

## Configuration
- `DIV_ZERO_FAST_EN`
  - Defined: when the sampled divisor is 0, IDLE goes directly to DONE. `busy` is high only in cycle 0, `done` and the divide-by-zero result appear in cycle 1, and `q`/`r` are written at the IDLE→DONE edge.
  - Undefined: divide-by-zero takes the full 33-cycle path with the same result values.
  - Nonzero divisors behave identically either way.

## Test plan
- DIVU 100 / 7: `start` at cycle 0 → `busy` high cycles 0–32, `done` at cycle 33, `q`=14, `r`=2.
- DIV 0xFFFFFFF9 (−7) / 2: → `q`=0xFFFFFFFD, `r`=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (−2): → `q`=0xFFFFFFFD, `r`=1.
- DIV 0x80000000 / 0xFFFFFFFF: → `q`=0x80000000, `r`=0, no hang, `done` at cycle 33.
- DIVU 5 / 0:
  - → `q`=0xFFFFFFFF, `r`=5.
  - `done` at cycle 33 without the macro; `done` at cycle 1 and `busy` only in cycle 0 with `DIV_ZERO_FAST_EN`.
- Prior result `q`=14, `r`=2, then a new `start` followed by `cancel` at cycle 10 → `busy`=0 from cycle 11, no `done`, `q`/`r` still 14/2. `start` held through DONE → exactly one `done`.
- `rst_n` low at cycle 20 of a run → `busy`, `done`, `q`, `r` = 0 immediately. After release, DIVU 9 / 3 completes in 33 cycles with `q`=3, `r`=0.

Source files
------------

// File: rtl/iter_div_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The issuing pipeline drives the master side and the divider owns the slave side.
interface iter_div_if;
  logic        start;
  logic        cancel;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;

  modport master (
    output start, cancel, is_signed, dividend, divisor,
    input  q, r, busy, done
  );

  modport slave (
    input  start, cancel, is_signed, dividend, divisor,
    output q, r, busy, done
  );
endinterface

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle over 32 RUN cycles, then a single DONE cycle.
// LO = q (quotient), HI = r (remainder).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and finishes
// in the cycle after start, with the same divide-by-zero result.
module iter_div (
  input logic       clk,
  input logic       rst_n,
  iter_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        accept;
  logic        finish;

  // Partial remainder already shifted with its next dividend bit, ready
  // for the trial subtract.
  logic [32:0] pr;
  // Remaining dividend bits leave from the top, quotient bits enter at the bottom.
  logic [31:0] dq;
  logic [31:0] dvs_mag;
  logic [31:0] dvd_raw;
  logic        neg_q;
  logic        neg_r;
  logic        dvs_zero;

  logic        take;
  logic [31:0] rem_step;
  logic [31:0] q_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic [31:0] dvd_mag_in;
  logic [31:0] dvs_mag_in;
  logic [31:0] q_reg;
  logic [31:0] r_reg;

`ifdef DIV_ZERO_FAST_EN
  logic        fast_zero;
`endif

  // Absolute value of an operand; unsigned operands pass through unchanged.
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag_of(input logic signed [31:0] v, input logic sgn);
    if (sgn && (v < 0)) return 32'(-v);
    return 32'(v);
  endfunction

  // Re-apply a sign to an unsigned magnitude (two's complement negate).
  function automatic logic [31:0] apply_sign(input logic [31:0] m, input logic neg);
    logic signed [31:0] s;
    s = signed'(m);
    return neg ? 32'(-s) : 32'(s);
  endfunction

  assign dvd_mag_in = mag_of(signed'(bus.dividend), bus.is_signed);
  assign dvs_mag_in = mag_of(signed'(bus.divisor), bus.is_signed);

  // One restoring step: trial subtract, keep on non-negative, record quotient bit.
  always_comb begin
    take     = (pr >= {1'b0, dvs_mag});
    rem_step = take ? (pr[31:0] - dvs_mag) : pr[31:0];
    q_mag    = {dq[30:0], take};
    if (dvs_zero) begin
      q_res = 32'hFFFF_FFFF;
      r_res = dvd_raw;
    end else begin
      q_res = apply_sign(q_mag, neg_q);
      r_res = apply_sign(rem_step, neg_r);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; cancel outranks start in IDLE and aborts RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          accept    = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (bus.divisor == 32'd0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_nxt = IDLE;
        end else if (cnt == 5'd31) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = accept && (bus.divisor == 32'd0);
`endif

  // Step counter: cleared on accept, advanced once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= 5'd0;
    else if (accept)         cnt <= 5'd0;
    else if (state == RUN)   cnt <= cnt + 5'd1;
  end

  // Operand capture on accept, then the iterating datapath during RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      pr       <= {32'd0, dvd_mag_in[31]};
      dq       <= {dvd_mag_in[30:0], 1'b0};
      dvs_mag  <= dvs_mag_in;
      dvd_raw  <= bus.dividend;
      neg_q    <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
      neg_r    <= bus.is_signed & bus.dividend[31];
      dvs_zero <= (bus.divisor == 32'd0);
    end else if (state == RUN) begin
      pr <= {rem_step, dq[31]};
      dq <= q_mag;
    end
  end

  // Architectural results, written only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 32'd0;
      r_reg <= 32'd0;
    end else if (finish) begin
      q_reg <= q_res;
      r_reg <= r_res;
    end
`ifdef DIV_ZERO_FAST_EN
    else if (fast_zero) begin
      q_reg <= 32'hFFFF_FFFF;
      r_reg <= bus.dividend;
    end
`endif
  end

  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.done = (state == DONE);
  // Stall the PC from the accepting cycle through the last RUN cycle.
  assign bus.busy = rst_n & (((state == IDLE) & bus.start & ~bus.cancel) | (state == RUN));

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div: the driver pushes reference results, a
// monitor pops and compares on every done pulse.
module tb_iter_div;

  logic clk;
  logic rst_n;
  iter_div_if ifc();

  iter_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with the MIPS special cases.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = 32'h8000_0000;
        er = 32'd0;
      end else begin
        eq = 32'($signed(a) / $signed(b));
        er = 32'($signed(a) % $signed(b));
      end
    end else begin
      eq = a / b;
      er = a % b;
    end
    return {eq, er};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 want no pending result at %0t", $time);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("result_q", ifc.q, e[63:32]);
        chk("result_r", ifc.r, e[31:0]);
      end
    end
  end

  // Issue one division and check busy/done cycle by cycle up to one cycle past done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hold);
    int exp_done;
    exp_done = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) exp_done = 1;
`endif
    sb.push_back(ref_div(a, b, s));
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.is_signed = s; ifc.dividend = a; ifc.divisor = b;
    @(negedge clk);
    chk("busy_c0", 32'(ifc.busy), 32'd1);
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(posedge clk); #1;
      if (!hold || k > exp_done) ifc.start = 1'b0;
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), 32'(ifc.busy), (k < exp_done) ? 32'd1 : 32'd0);
      chk($sformatf("done_c%0d", k), 32'(ifc.done), (k == exp_done) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.cancel = 1'b0; ifc.is_signed = 1'b0;
    ifc.dividend = 32'd0; ifc.divisor = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ifc.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_q", ifc.q, 32'd0);
    chk("rst_r", ifc.r, 32'd0);
    ifc.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases.
    run_div(32'd100, 32'd7, 1'b0, 1'b0);

    // Cancel at cycle 10 leaves the prior 14/2 in place.
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.is_signed = 1'b0; ifc.dividend = 32'd1000; ifc.divisor = 32'd3;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      ifc.start  = 1'b0;
      ifc.cancel = (k == 10);
      @(negedge clk);
      if (k >= 11) chk($sformatf("cancel_busy_c%0d", k), 32'(ifc.busy), 32'd0);
    end
    chk("cancel_q", ifc.q, 32'd14);
    chk("cancel_r", ifc.r, 32'd2);

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 1'b1);
    run_div(32'd123, 32'd10, 1'b1, 1'b1);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.is_signed = 1'b0; ifc.dividend = 32'd12345; ifc.divisor = 32'd67;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      ifc.start = 1'b0;
    end
    rst_n = 1'b0;
    ifc.start = 1'b1;
    #1;
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_done", 32'(ifc.done), 32'd0);
    chk("midrst_q", ifc.q, 32'd0);
    chk("midrst_r", ifc.r, 32'd0);
    ifc.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_div(32'd9, 32'd3, 1'b0, 1'b0);

    // Randomized cases with corner-biased divisors.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      int sel;
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = -$urandom_range(1, 15);
      run_div(a, b, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
